// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART_Sender TX path among NREQ requesters.
// Optional feature macro: UART_ARB_TIMEOUT_EN (abort WAIT_BUSY after BUSY_TIMEOUT cycles).
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned BUSY_TIMEOUT = 1024,
    localparam int unsigned OW          = $clog2(NREQ)
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    output logic [7:0]          TX_DATA,
    output logic                TX_EN,
    input  logic                TX_STATUS,
    output logic [OW-1:0]       owner,
    output logic                arb_busy,
    output logic                tx_done,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [OW-1:0]   ptr, ptr_next;
    logic [OW-1:0]   owner_next;
    logic [OW-1:0]   pick_idx;
    logic [OW-1:0]   cand;
    logic            pick_valid;
    logic [NREQ-1:0] ack_next;
    logic [7:0]      tx_data_next;
    logic            tx_en_next;
    logic            tx_done_next;
    logic            arb_busy_next;
    logic            timeout_err_next;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);
    logic [CW-1:0]   busy_cnt, busy_cnt_next;
`endif

    // Legal range guard: an out-of-range configuration has no g_cfg_ok scope
    if (NREQ >= 2 && NREQ <= 8 && BUSY_TIMEOUT >= 1) begin : g_cfg_ok
    end

    // Round-robin search: first requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = OW'((32'(ptr) + 32'(k)) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_next       = state;
        ptr_next         = ptr;
        owner_next       = owner;
        tx_data_next     = TX_DATA;
        ack_next         = '0;
        tx_en_next       = 1'b0;
        tx_done_next     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_err_next = timeout_err;
        busy_cnt_next    = busy_cnt;
`else
        timeout_err_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (TX_STATUS && pick_valid) begin
                    tx_data_next       = req_data[8*pick_idx +: 8];
                    owner_next         = pick_idx;
                    ack_next[pick_idx] = 1'b1;
                    ptr_next           = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
                    state_next         = ISSUE;
                end
            end
            ISSUE: begin
                tx_en_next    = 1'b1;
                state_next    = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                busy_cnt_next = '0;
`endif
            end
            WAIT_BUSY: begin
                if (!TX_STATUS) begin
                    state_next = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (busy_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    state_next       = IDLE;
                    timeout_err_next = 1'b1;
                end else begin
                    busy_cnt_next = busy_cnt + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (TX_STATUS) begin
                    tx_done_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        arb_busy_next = (state_next != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            TX_DATA     <= '0;
            ack         <= '0;
            TX_EN       <= 1'b0;
            tx_done     <= 1'b0;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            busy_cnt    <= '0;
`endif
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            owner       <= owner_next;
            TX_DATA     <= tx_data_next;
            ack         <= ack_next;
            TX_EN       <= tx_en_next;
            tx_done     <= tx_done_next;
            arb_busy    <= arb_busy_next;
            timeout_err <= timeout_err_next;
`ifdef UART_ARB_TIMEOUT_EN
            busy_cnt    <= busy_cnt_next;
`endif
        end
    end

endmodule
